// File: rtl/fre_meas.sv
// ---------------------------------------------------------------------------
// fre_meas -- frequency / duty meter for a slow square wave.
//
// Measures an asynchronous square wave in units of clk cycles. The input
// passes through a three-flop chain. Edges are detected on the last two
// flops. The meter reports the rising-to-rising interval (period) and the
// rising-to-falling interval (high_time) once per completed input period.
//
// Parameters
//   CNT_W    width of period, high_time and the internal cycle counter
//   TIMEOUT  cycles without a qualifying edge before a stall is flagged
//            (must be > 1 and < 2**CNT_W)
//
// Ports
//   clk         system clock, all logic on the rising edge
//   rst         synchronous, active-high reset
//   en          measurement enable; low forces IDLE without losing results
//   sig_in      asynchronous square wave under measurement
//   period      last rising-to-rising interval, in clk cycles
//   high_time   last rising-to-falling interval, in clk cycles
//   meas_valid  one-cycle pulse when period/high_time are updated
//   timeout     sticky stall flag, cleared by the next meas_valid or rst
//   busy        registered (state != IDLE)
// ---------------------------------------------------------------------------
module fre_meas #(
    parameter int               CNT_W   = 25,
    parameter logic [CNT_W-1:0] TIMEOUT = 25'd25_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOW  = 2'd1,
        WAIT_RISE = 2'd2,
        MEAS      = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic             s1;
    logic             s2;
    logic             s3;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_tmp;
    logic             rise;
    logic             fall;
    logic             tmo_hit;

    // Stage: input synchroniser. s1 may go metastable; only s2/s3 are used.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Stage: edge detection on the settled pair.
    assign rise    = s2 & ~s3;
    assign fall    = ~s2 & s3;
    assign tmo_hit = (cnt == TIMEOUT);

    // Stage: measurement FSM with registered outputs.
    // cnt counts cycles since the last rise in MEAS, or cycles spent in the
    // current wait state otherwise. It is pulled back to 0 whenever it reaches
    // TIMEOUT, so it can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= CNT_ZERO;
            hi_tmp     <= CNT_ZERO;
            period     <= CNT_ZERO;
            high_time  <= CNT_ZERO;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!en) begin
                // Results and the stall flag survive a disable.
                state <= IDLE;
                cnt   <= CNT_ZERO;
                busy  <= 1'b0;
            end else begin
                // With en high the next state is never IDLE.
                busy <= 1'b1;
                unique case (state)
                    IDLE: begin
                        state <= WAIT_LOW;
                        cnt   <= CNT_ZERO;
                    end

                    // Require a low level first, so a sync chain that was just
                    // cleared by reset while sig_in is high cannot fake a rise.
                    WAIT_LOW: begin
                        if (tmo_hit) begin
                            timeout <= 1'b1;
                            state   <= WAIT_LOW;
                            cnt     <= CNT_ZERO;
                        end else if (!s2) begin
                            state <= WAIT_RISE;
                            cnt   <= CNT_ZERO;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    // The first rise only opens the measurement window.
                    WAIT_RISE: begin
                        if (rise) begin
                            state <= MEAS;
                            cnt   <= CNT_ONE;
                        end else if (tmo_hit) begin
                            timeout <= 1'b1;
                            state   <= WAIT_LOW;
                            cnt     <= CNT_ZERO;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    MEAS: begin
                        if (fall) begin
                            hi_tmp <= cnt;
                        end
                        // A rise on the timeout cycle still completes the period.
                        if (rise) begin
                            period     <= cnt;
                            high_time  <= hi_tmp;
                            meas_valid <= 1'b1;
                            timeout    <= 1'b0;
                            cnt        <= CNT_ONE;
                        end else if (tmo_hit) begin
                            timeout <= 1'b1;
                            state   <= WAIT_LOW;
                            cnt     <= CNT_ZERO;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        cnt   <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fre_meas.sv
// ---------------------------------------------------------------------------
// tb_fre_meas -- self-checking bench for fre_meas.
// A timestamp-based reference model predicts every output on every cycle.
// Directed scenarios add literal expectations, and random segments follow.
// ---------------------------------------------------------------------------
module tb_fre_meas;

    localparam int               CNT_W = 25;
    localparam logic [CNT_W-1:0] TO    = 25'd100;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             timeout;
    logic             busy;

    fre_meas #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sig_in     (sig_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .timeout    (timeout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model (timestamps, not counters) ----------
    typedef enum int {M_IDLE, M_WLOW, M_WRISE, M_MEAS} mph_t;
    mph_t     ph = M_IDLE;
    int       cyc = 0;          // number of rising clk edges so far
    int       t_mark = 0;       // edge at which the current interval started
    int       hi_m = 0;
    logic [2:0] hist = 3'b000;  // [0]=first flop, [1]=second, [2]=third
    int       exp_period = 0;
    int       exp_high = 0;
    logic     exp_valid = 1'b0;
    logic     exp_timeout = 1'b0;
    logic     exp_busy = 1'b0;

    task automatic model_step();
        logic r;
        logic f;
        int   el;
        cyc++;
        if (rst) begin
            ph = M_IDLE; t_mark = cyc; hi_m = 0; hist = 3'b000;
            exp_period = 0; exp_high = 0; exp_valid = 1'b0;
            exp_timeout = 1'b0; exp_busy = 1'b0;
        end else begin
            r = hist[1] & ~hist[2];
            f = ~hist[1] & hist[2];
            exp_valid = 1'b0;
            if (!en) begin
                ph = M_IDLE;
                exp_busy = 1'b0;
            end else begin
                exp_busy = 1'b1;
                // Elapsed cycles: since the rise in MEAS, or since entry to a wait.
                el = (ph == M_MEAS) ? (cyc - t_mark) : (cyc - t_mark - 1);
                case (ph)
                    M_IDLE: begin ph = M_WLOW; t_mark = cyc; end
                    M_WLOW: begin
                        if (el == int'(TO)) begin exp_timeout = 1'b1; t_mark = cyc; end
                        else if (!hist[1]) begin ph = M_WRISE; t_mark = cyc; end
                    end
                    M_WRISE: begin
                        if (r) begin ph = M_MEAS; t_mark = cyc; end
                        else if (el == int'(TO)) begin exp_timeout = 1'b1; ph = M_WLOW; t_mark = cyc; end
                    end
                    default: begin
                        if (f) hi_m = el;
                        if (r) begin
                            exp_period = el; exp_high = hi_m; exp_valid = 1'b1;
                            exp_timeout = 1'b0; t_mark = cyc;
                        end else if (el == int'(TO)) begin
                            exp_timeout = 1'b1; ph = M_WLOW; t_mark = cyc;
                        end
                    end
                endcase
            end
            hist = {hist[1:0], sig_in};
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Single compare process, one cycle-accurate check per output per cycle.
    initial forever begin
        @(posedge clk);
        #1;
        chk("period",     32'(period),     32'(exp_period));
        chk("high_time",  32'(high_time),  32'(exp_high));
        chk("meas_valid", 32'(meas_valid), 32'(exp_valid));
        chk("timeout",    32'(timeout),    32'(exp_timeout));
        chk("busy",       32'(busy),       32'(exp_busy));
    end

    // ---------------- stimulus generator ----------------------------------
    logic gen_on = 1'b0;
    logic man_level = 1'b0;
    int   hi_len = 4;
    int   lo_len = 4;
    int   gcnt = 0;
    int   rise_cyc = 0;

    initial forever begin
        @(negedge clk);
        if (!gen_on) begin
            sig_in = man_level;
            gcnt = 0;
        end else begin
            gcnt++;
            if (sig_in && gcnt >= hi_len) begin
                sig_in = 1'b0; gcnt = 0;
            end else if (!sig_in && gcnt >= lo_len) begin
                sig_in = 1'b1; gcnt = 0; rise_cyc = cyc;
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_valid(input string nm, input int maxc);
        bit got;
        got = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            tick(1);
            if (meas_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL %s: no meas_valid within %0d cycles (required one)", nm, maxc);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcyc;
        int k;
        bit got;

        // Reset state
        tick(3);
        chk("rst_period", 32'(period), 0);
        chk("rst_high", 32'(high_time), 0);
        chk("rst_valid", 32'(meas_valid), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_busy", 32'(busy), 0);

        // Divider period 8
        rst = 1'b0; en = 1'b1;
        hi_len = 4; lo_len = 4; gen_on = 1'b1;
        wait_valid("div8_first", 100);
        chk("div8_period", 32'(period), 8);
        chk("div8_high", 32'(high_time), 4);
        chk("div8_timeout", 32'(timeout), 0);
        vcyc = cyc;
        wait_valid("div8_second", 20);
        chk("div8_spacing", 32'(cyc - vcyc), 8);

        // Custom pulse 3 high / 9 low, plus latency
        hi_len = 3; lo_len = 9;
        wait_valid("pulse_a", 60);
        wait_valid("pulse_b", 60);
        wait_valid("pulse_c", 60);
        chk("pulse_period", 32'(period), 12);
        chk("pulse_high", 32'(high_time), 3);
        chk("pulse_latency", 32'(cyc - rise_cyc), 3);

        // Timeout after freeze, then recovery
        hi_len = 4; lo_len = 4;
        wait_valid("tmo_a", 60);
        wait_valid("tmo_b", 60);
        man_level = sig_in; gen_on = 1'b0;
        vcyc = cyc;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (timeout === 1'b1) begin got = 1'b1; break; end
        end
        chk("tmo_seen", 32'(got), 1);
        chk("tmo_delay", 32'(cyc - vcyc), 100);
        chk("tmo_period_hold", 32'(period), 8);
        gen_on = 1'b1;
        wait_valid("tmo_recover", 300);
        chk("tmo_cleared", 32'(timeout), 0);
        chk("tmo_rec_period", 32'(period), 8);

        // Enable dropped mid-measurement
        wait_valid("en_pre", 30);
        tick(3);
        en = 1'b0;
        tick(1);
        chk("en_busy", 32'(busy), 0);
        en = 1'b1;
        wait_valid("en_resume", 100);
        chk("en_period", 32'(period), 8);
        chk("en_high", 32'(high_time), 4);

        // Reset during MEAS
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("mrst_period", 32'(period), 0);
        chk("mrst_high", 32'(high_time), 0);
        chk("mrst_busy", 32'(busy), 0);
        rst = 1'b0;
        wait_valid("mrst_resume", 100);
        chk("mrst_rperiod", 32'(period), 8);
        chk("mrst_rhigh", 32'(high_time), 4);

        // sig_in held high through reset, then toggle every 10
        rst = 1'b1; en = 1'b0; gen_on = 1'b0; man_level = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        en = 1'b1;
        tick(15);
        hi_len = 10; lo_len = 10; gen_on = 1'b1;
        wait_valid("hold_first", 200);
        chk("hold_period", 32'(period), 20);
        chk("hold_high", 32'(high_time), 10);

        // Randomised segments, checked by the model every cycle
        for (int s = 0; s < 40; s++) begin
            k = $urandom_range(0, 9);
            if (k == 0) begin
                gen_on = 1'b0;
                man_level = 1'($urandom_range(0, 1));
                tick($urandom_range(60, 180));
            end else if (k == 1) begin
                en = 1'b0;
                tick($urandom_range(1, 5));
                en = 1'b1;
                tick($urandom_range(10, 40));
            end else if (k == 2) begin
                rst = 1'b1;
                tick($urandom_range(1, 2));
                rst = 1'b0;
                tick($urandom_range(10, 40));
            end else begin
                hi_len = $urandom_range(1, 16);
                lo_len = $urandom_range(1, 16);
                gen_on = 1'b1;
                tick($urandom_range(30, 150));
            end
        end

        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
